// File: rtl/work_pkg.sv
// Shared definitions for the work-unit serial transmitter and its bit timer.
// State encodings are one-hot so each state decodes from a single flop.
package work_pkg;

    localparam int WORK_BITS      = 512;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_START = 5'b00010,
        ST_DATA  = 5'b00100,
        ST_STOP  = 5'b01000,
        ST_GAP   = 5'b10000
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: tick is high on the last clk cycle of every bit-time.
// The owner pulses restart to start a fresh bit-time on the following cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;

    assign tick = (baud_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt <= '0;
        end else if (restart || tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/work_transmit.sv
// Serialises a captured {midstate,data2} work unit as BYTES UART 8N1 characters,
// most significant byte first, each byte LSB-first, with optional mark gaps.
module work_transmit
    import work_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int BYTES        = 64,
    parameter int GAP_BITS     = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         send,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         TxD,
    output logic         busy,
    output logic         done
);

    localparam int             BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [3:0]     GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

    tx_state_t            state;
    tx_state_t            state_next;
    logic [WORK_BITS-1:0] shadow;
    logic [WORK_BITS-1:0] shadow_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_next;
    logic [BCW-1:0]       byte_cnt;
    logic [BCW-1:0]       byte_cnt_next;
    logic [3:0]           gap_cnt;
    logic [3:0]           gap_cnt_next;
    logic [UART_DATA_BITS-1:0] next_byte;
    logic                 tick;
    logic                 timer_restart;
    logic                 byte_end;
    logic                 frame_end;
    logic                 accept;
    logic                 tx_next;

    // Hold the timer cleared while idle and restart it on every state entry.
    assign timer_restart = (state == ST_IDLE) || (state_next != state);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (timer_restart),
        .tick    (tick)
    );

    always_comb begin
        state_next    = state;
        shadow_next   = shadow;
        bit_cnt_next  = bit_cnt;
        byte_cnt_next = byte_cnt;
        gap_cnt_next  = gap_cnt;
        byte_end      = 1'b0;
        frame_end     = 1'b0;
        accept        = 1'b0;
        tx_next       = 1'b1;
        next_byte     = '0;

        case (state)
            ST_IDLE: begin
                accept = send;
            end
            ST_START: begin
                if (tick) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (GAP_BITS == 0) begin
                        byte_end = 1'b1;
                    end else begin
                        state_next   = ST_GAP;
                        gap_cnt_next = 4'd0;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        byte_end = 1'b1;
                    end else begin
                        gap_cnt_next = gap_cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A request still high at the frame end restarts immediately, so busy never drops.
        if (byte_end) begin
            if (byte_cnt == LAST_BYTE) begin
                frame_end     = 1'b1;
                state_next    = ST_IDLE;
                byte_cnt_next = '0;
                accept        = send;
            end else begin
                byte_cnt_next = byte_cnt + 1'b1;
                shadow_next   = shadow << UART_DATA_BITS;
                state_next    = ST_START;
            end
        end

        if (accept) begin
            shadow_next   = {midstate, data2};
            byte_cnt_next = '0;
            bit_cnt_next  = 3'd0;
            gap_cnt_next  = 4'd0;
            state_next    = ST_START;
        end

        // TxD is registered from the next-state view so the line never glitches.
        next_byte = shadow_next[WORK_BITS-1 -: UART_DATA_BITS];
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = next_byte[bit_cnt_next];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shadow   <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            gap_cnt  <= 4'd0;
            TxD      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            shadow   <= shadow_next;
            bit_cnt  <= bit_cnt_next;
            byte_cnt <= byte_cnt_next;
            gap_cnt  <= gap_cnt_next;
            TxD      <= tx_next;
            busy     <= (state_next != ST_IDLE);
            done     <= frame_end;
        end
    end

endmodule

// File: tb/tb_work_transmit.sv
// Bench for work_transmit: a mid-bit UART sampler decodes TxD and checks every
// byte and done pulse against expectations queued when each frame is requested.
module tb_work_transmit;

    localparam int CPB     = 4;
    localparam int A_BYTES = 64;
    localparam int B_BYTES = 2;
    localparam int B_GAP   = 2;
    localparam int A_FRAME = A_BYTES * 10 * CPB;
    localparam int B_FRAME = B_BYTES * (10 + B_GAP) * CPB;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         send_a = 1'b0;
    logic         send_b = 1'b0;
    logic [255:0] midstate = '0;
    logic [255:0] data2 = '0;
    logic         txd_a, busy_a, done_a;
    logic         txd_b, busy_b, done_b;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           done_seen = 0;
    bit           gap_mode = 1'b0;
    logic [7:0]   exp_bytes[$];
    int           exp_done[$];

    int           rx_pos = -1;
    logic [7:0]   rx_byte = '0;
    logic         line_s, done_s;

    work_transmit #(.CLKS_PER_BIT(CPB), .BYTES(A_BYTES), .GAP_BITS(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .send(send_a), .midstate(midstate), .data2(data2),
        .TxD(txd_a), .busy(busy_a), .done(done_a)
    );

    work_transmit #(.CLKS_PER_BIT(CPB), .BYTES(B_BYTES), .GAP_BITS(B_GAP)) dut_b (
        .clk(clk), .reset_n(reset_n), .send(send_b), .midstate(midstate), .data2(data2),
        .TxD(txd_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] actual);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got %0h, expected nothing (cycle %0d)", name, actual, cyc);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: a frame is simply the first n bytes of the 512-bit word, top byte first.
    task automatic push_frame(input logic [511:0] w, input int n);
        for (int k = 0; k < n; k++) exp_bytes.push_back(w[511 - 8*k -: 8]);
    endtask

    task automatic wait_done(input int target, input int budget);
        int spent = 0;
        while (done_seen < target && spent < budget) begin
            @(negedge clk);
            spent++;
        end
        if (done_seen < target) flag_fail("done_timeout", done_seen);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // UART sampler and scoreboard consumer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            line_s = gap_mode ? txd_b : txd_a;
            done_s = gap_mode ? done_b : done_a;
            if (!reset_n) begin
                rx_pos = -1;
                continue;
            end
            if (done_s) begin
                if (exp_done.size() == 0) flag_fail("unexpected_done", cyc);
                else check_output("done_cycle", cyc, exp_done.pop_front());
                done_seen++;
            end
            if (rx_pos < 0) begin
                if (line_s == 1'b0) rx_pos = 0;
            end else begin
                rx_pos++;
            end
            if (rx_pos == CPB/2) begin
                if (line_s !== 1'b0) begin
                    flag_fail("start_bit", line_s);
                    rx_pos = -1;
                end
            end else if (rx_pos > CPB/2 && ((rx_pos - CPB/2) % CPB) == 0) begin
                if ((rx_pos - CPB/2) / CPB <= 8) begin
                    rx_byte[(rx_pos - CPB/2) / CPB - 1] = line_s;
                end else begin
                    check_output("stop_bit", line_s, 1'b1);
                    if (exp_bytes.size() == 0) flag_fail("unexpected_byte", rx_byte);
                    else check_output("rx_byte", rx_byte, exp_bytes.pop_front());
                    rx_pos = -1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] w1, w2;
        int t0, low_cnt, prev_done;

        // Reset held with send high: outputs idle, frame starts on the first edge after release.
        reset_n = 1'b0;
        send_a  = 1'b1;
        for (int k = 0; k < 32; k++) begin
            midstate[255 - 8*k -: 8] = 8'(k);
            data2[255 - 8*k -: 8]    = 8'(8'hA0 + k);
        end
        repeat (3) @(negedge clk);
        check_output("reset_txd_a", txd_a, 1'b1);
        check_output("reset_busy_a", busy_a, 1'b0);
        check_output("reset_done_a", done_a, 1'b0);
        check_output("reset_txd_b", txd_b, 1'b1);
        check_output("reset_busy_b", busy_b, 1'b0);
        for (int k = 0; k < 32; k++) exp_bytes.push_back(8'(k));
        for (int k = 0; k < 32; k++) exp_bytes.push_back(8'(8'hA0 + k));
        exp_done.push_back(cyc + 1 + A_FRAME);
        reset_n = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        check_output("accept_busy", busy_a, 1'b1);
        check_output("accept_start_bit", txd_a, 1'b0);
        wait_done(1, A_FRAME + 20);
        check_output("end_busy", busy_a, 1'b0);
        check_output("end_txd_idle", txd_a, 1'b1);

        // Requests while busy are dropped; the frame keeps its capture-time contents.
        w1 = {rand256(), rand256()};
        {midstate, data2} = w1;
        push_frame(w1, A_BYTES);
        exp_done.push_back(cyc + 1 + A_FRAME);
        send_a = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        send_a = 1'b0;
        wait_until(t0 + 5);
        midstate = rand256();
        wait_until(t0 + 100);
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        wait_until(t0 + 900);
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        wait_done(2, A_FRAME + 20);
        low_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy_a) low_cnt++;
        end
        check_output("ignored_send_busy_cycles", low_cnt, 0);

        // Back-to-back frames with send held: no idle time and busy never drops.
        w1 = {rand256(), rand256()};
        w2 = {rand256(), rand256()};
        {midstate, data2} = w1;
        push_frame(w1, A_BYTES);
        push_frame(w2, A_BYTES);
        exp_done.push_back(cyc + 1 + A_FRAME);
        exp_done.push_back(cyc + 1 + 2 * A_FRAME);
        send_a = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        {midstate, data2} = w2;
        low_cnt = 0;
        while (cyc < t0 + 2 * A_FRAME) begin
            @(negedge clk);
            if (cyc == t0 + A_FRAME) begin
                send_a = 1'b0;
                check_output("b2b_second_start", txd_a, 1'b0);
                check_output("b2b_done_pulse", done_a, 1'b1);
            end
            if (cyc < t0 + 2 * A_FRAME && !busy_a) low_cnt++;
        end
        check_output("b2b_busy_low_cycles", low_cnt, 0);
        wait_done(4, 20);
        check_output("b2b_end_busy", busy_a, 1'b0);

        // Gap variant: two bytes, two mark bit-times after each stop bit.
        gap_mode = 1'b1;
        midstate = {16'h55AA, 240'(rand256())};
        data2    = rand256();
        exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'hAA);
        exp_done.push_back(cyc + 1 + B_FRAME);
        send_b = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        send_b = 1'b0;
        wait_until(t0 + 44);
        check_output("gap_mark", txd_b, 1'b1);
        check_output("gap_busy", busy_b, 1'b1);
        wait_until(t0 + 48);
        check_output("gap_next_start", txd_b, 1'b0);
        wait_done(5, B_FRAME + 20);
        w1 = {rand256(), rand256()};
        {midstate, data2} = w1;
        push_frame(w1, B_BYTES);
        exp_done.push_back(cyc + 1 + B_FRAME);
        send_b = 1'b1;
        @(negedge clk);
        send_b = 1'b0;
        wait_done(6, B_FRAME + 20);
        check_output("gap_end_busy", busy_b, 1'b0);
        repeat (4) @(negedge clk);
        gap_mode = 1'b0;

        // Mid-frame reset: line returns to mark at once, no done, next frame is clean.
        w1 = {rand256(), rand256()};
        {midstate, data2} = w1;
        push_frame(w1, A_BYTES);
        exp_done.push_back(cyc + 1 + A_FRAME);
        send_a = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        send_a = 1'b0;
        wait_until(t0 + 200);
        check_output("pre_reset_start_bit", txd_a, 1'b0);
        prev_done = done_seen;
        reset_n = 1'b0;
        exp_bytes.delete();
        exp_done.delete();
        #1;
        check_output("reset_mid_txd", txd_a, 1'b1);
        check_output("reset_mid_busy", busy_a, 1'b0);
        repeat (5) @(negedge clk);
        check_output("reset_mid_no_done", done_seen, prev_done);
        reset_n = 1'b1;
        @(negedge clk);
        w2 = {rand256(), rand256()};
        {midstate, data2} = w2;
        push_frame(w2, A_BYTES);
        exp_done.push_back(cyc + 1 + A_FRAME);
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        wait_done(prev_done + 1, A_FRAME + 20);
        check_output("post_reset_busy", busy_a, 1'b0);

        repeat (10) @(negedge clk);
        check_output("leftover_bytes", exp_bytes.size(), 0);
        check_output("leftover_dones", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
